// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-port bundle for mem_access_ctrl.
// The master view belongs to the controller, the slave view to the pipeline/memory side.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a 4-byte-wide memory that acts on address changes.
// Sub-word stores are read-modify-write; defining RANGE_CHECK_EN rejects requests past MEM_TOP.
module mem_access_ctrl #(
    parameter int unsigned MEM_LAT   = 1,
    parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF,
    parameter logic [31:0] MEM_TOP   = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, PARK} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

`ifdef RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  lat_cnt_reg, lat_cnt_next;
    logic              we_reg, we_next;
    logic [1:0]        size_reg, size_next;
    logic              sgn_reg, sgn_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic [31:0]       rd_reg, rd_next;
    logic              wphase_reg, wphase_next;
    logic              err_reg, err_next;

    logic              req_ready_reg, req_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [31:0]       rsp_rdata_reg, rsp_rdata_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic              mem_rw_reg, mem_rw_next;

    // 33-bit end address so that wrap-around counts as out of range
    logic [32:0]       req_end;
    logic              req_bad;
    logic              accept;
    logic              needs_rmw;

    assign req_end = {1'b0, bus.req_addr} + 33'd3;
    assign req_bad = (bus.req_size == SZ_RSVD)
                  || (RANGE_CHECK && (req_end > {1'b0, MEM_TOP}));
    assign accept  = bus.req_valid && req_ready_reg && (state_reg == IDLE);
    assign needs_rmw = we_reg && (size_reg != SZ_WORD) && !err_reg && !wphase_reg;

    // Byte lanes owned by the request: written on store merge, kept on load extraction
    logic [3:0]  lane_keep;
    logic        fill_bit;
    logic [31:0] merged_data;
    logic [31:0] load_data;

    always_comb begin
        case (size_reg)
            SZ_BYTE: lane_keep = 4'b0001;
            SZ_HALF: lane_keep = 4'b0011;
            default: lane_keep = 4'b1111;
        endcase
    end

    assign fill_bit = sgn_reg && ((size_reg == SZ_BYTE) ? rd_reg[7] : rd_reg[15]);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_data[8*gi +: 8] = lane_keep[gi] ? wdata_reg[8*gi +: 8] : rd_reg[8*gi +: 8];
            assign load_data[8*gi +: 8]   = lane_keep[gi] ? rd_reg[8*gi +: 8] : {8{fill_bit}};
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        lat_cnt_next   = lat_cnt_reg;
        we_next        = we_reg;
        size_next      = size_reg;
        sgn_next       = sgn_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rd_next        = rd_reg;
        wphase_next    = wphase_reg;
        err_next       = err_reg;
        req_ready_next = req_ready_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_rw_next    = mem_rw_reg;

        case (state_reg)
            IDLE: begin
                req_ready_next = 1'b1;
                if (accept) begin
                    req_ready_next = 1'b0;
                    we_next        = bus.req_we;
                    size_next      = bus.req_size;
                    sgn_next       = bus.req_signed;
                    addr_next      = bus.req_addr;
                    wdata_next     = bus.req_wdata;
                    wphase_next    = 1'b0;
                    err_next       = req_bad;
                    if (req_bad) begin
                        state_next = PARK;
                    end else begin
                        state_next = SETUP;
                        // Sub-word stores start with a read phase; only word stores write first
                        mem_rw_next = bus.req_we && (bus.req_size == SZ_WORD);
                        if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                            mem_wdata_next = bus.req_wdata;
                        end
                    end
                end
            end

            SETUP: begin
                state_next    = ACCESS;
                mem_addr_next = addr_reg;
                lat_cnt_next  = CNT_LAST;
            end

            ACCESS: begin
                if (lat_cnt_reg == '0) begin
                    state_next    = PARK;
                    mem_addr_next = IDLE_ADDR;
                    if (!mem_rw_reg) begin
                        rd_next = bus.mem_rdata;
                    end
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end

            PARK: begin
                if (needs_rmw) begin
                    state_next     = SETUP;
                    wphase_next    = 1'b1;
                    mem_rw_next    = 1'b1;
                    mem_wdata_next = merged_data;
                end else begin
                    state_next     = IDLE;
                    req_ready_next = 1'b1;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = err_reg;
                    mem_rw_next    = 1'b0;
                    if (err_reg) begin
                        rsp_rdata_next = 32'h0;
                    end else if (!we_reg) begin
                        rsp_rdata_next = load_data;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lat_cnt_reg   <= '0;
            we_reg        <= 1'b0;
            size_reg      <= 2'b00;
            sgn_reg       <= 1'b0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            rd_reg        <= 32'h0;
            wphase_reg    <= 1'b0;
            err_reg       <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
            mem_addr_reg  <= IDLE_ADDR;
            mem_wdata_reg <= 32'h0;
            mem_rw_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lat_cnt_reg   <= lat_cnt_next;
            we_reg        <= we_next;
            size_reg      <= size_next;
            sgn_reg       <= sgn_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rd_reg        <= rd_next;
            wphase_reg    <= wphase_next;
            err_reg       <= err_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_rw_reg    <= mem_rw_next;
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_rw    = mem_rw_reg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, abort-on-reset sequence and random
// transactions checked against a byte-array reference model of the memory contents.
module tb_mem_access_ctrl;
    localparam int          L         = 1;
    localparam logic [31:0] IDLE      = 32'hFFFF_FFFF;
    localparam int          MEM_BYTES = 4100;
    localparam int          LAT1      = L + 2;
    localparam int          LAT2      = 2 * (L + 2);

    logic clk;
    logic rst_n;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .MEM_LAT   (L),
        .IDLE_ADDR (IDLE),
        .MEM_TOP   (32'h0000_1000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External memory: 4 little-endian bytes at any address, writes while mem_rw is high
    logic [7:0]  dev_mem [0:MEM_BYTES-1];
    logic        dev_clear = 1'b1;
    logic        dev_hit;
    int unsigned dev_idx;

    always_comb begin
        dev_hit = (bus.mem_addr <= 32'd4096);
        dev_idx = dev_hit ? bus.mem_addr : 32'd0;
        bus.mem_rdata = dev_hit ? {dev_mem[dev_idx+3], dev_mem[dev_idx+2],
                                   dev_mem[dev_idx+1], dev_mem[dev_idx]} : 32'h0;
    end

    always @(posedge clk) begin
        if (dev_clear) begin
            for (int i = 0; i < MEM_BYTES; i++) dev_mem[i] <= 8'h00;
        end else if (bus.mem_rw && dev_hit) begin
            for (int i = 0; i < 4; i++) dev_mem[dev_idx+i] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // Port monitor: access/write cycle counts and mem_rw/mem_addr ordering violations
    logic        mon_en = 1'b0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          proto_viol = 0;
    logic [31:0] prev_addr = 32'hFFFF_FFFF;
    logic        prev_rw = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_addr != IDLE) begin
                acc_cnt <= acc_cnt + 1;
                if (bus.mem_rw) wr_cnt <= wr_cnt + 1;
            end
            if ((bus.mem_rw != prev_rw && !(prev_addr == IDLE && bus.mem_addr == IDLE)) ||
                (bus.mem_addr != IDLE && prev_addr != IDLE && bus.mem_addr != prev_addr))
                proto_viol <= proto_viol + 1;
        end
        prev_addr <= bus.mem_addr;
        prev_rw   <= bus.mem_rw;
    end

    // Reference model: memory image as bytes, loads computed arithmetically
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size,
                                             input logic sgn);
        logic [31:0] w;
        logic [31:0] v;
        w = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        case (size)
            2'd0: begin
                v = w % 256;
                if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = w % 65536;
                if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
        int n;
        n = 1 << size;
        for (int i = 0; i < n; i++) ref_mem[a+i] = 8'((d >> (8 * i)) % 256);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_acc;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_acc, input int exp_wr);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_lat = exp_lat; v.exp_acc = exp_acc; v.exp_wr = exp_wr;
        return v;
    endfunction

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int          k;
        int          lat;
        int          acc0;
        int          wr0;
        int          viol0;
        logic [31:0] rdata;
        logic        err;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        bus.req_valid  = 1'b1;
        acc0  = acc_cnt;
        wr0   = wr_cnt;
        viol0 = proto_viol;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_err"}, 32'(err), 32'(v.exp_err));
        chk({tag, "_access_cycles"}, 32'(acc_cnt - acc0), 32'(v.exp_acc));
        chk({tag, "_write_cycles"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
        chk({tag, "_rw_order"}, 32'(proto_viol - viol0), 32'd0);
        $display("txn %0d %s we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 txn_no, tag, v.we, v.size, v.sgn, v.addr, v.wdata, rdata, err, lat);
        txn_no++;
    endtask

    // Expected response derived from the reference model; also commits stores to it
    task automatic model_txn(input string tag, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                             inout logic [31:0] last_rdata);
        vec_t v;
        logic bad;
        logic rmw;
        bad = (size == 2'd3);
`ifdef RANGE_CHECK_EN
        if (64'(addr) + 64'd3 > 64'h1000) bad = 1'b1;
`endif
        rmw = we && (size != 2'd2);
        v = mk(we, size, sgn, addr, wdata, 32'h0, bad,
               bad ? 1 : (rmw ? LAT2 : LAT1),
               bad ? 0 : (rmw ? 2 * L : L),
               (bad || !we) ? 0 : L);
        if (!bad) v.exp_rdata = we ? last_rdata : ref_load(addr, size, sgn);
        run_txn(tag, v);
        last_rdata = v.exp_rdata;
        if (!bad && we) ref_store(addr, size, wdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] last_rdata;
        logic        seen;
        int          diffs;
        int          r;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Reset hold for three cycles
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        dev_clear = 1'b0;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, IDLE);
        chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Directed vectors
        vecs.push_back(mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h00000000, 0, LAT1, L, L));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 0, 1, 32'h103, 32'h0,        32'hFFFFFFDE, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 0, 0, 32'h103, 32'h0,        32'h000000DE, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 1, 1, 32'h100, 32'h0,        32'hFFFFBEEF, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 1, 0, 32'h102, 32'h0,        32'h0000DEAD, 0, LAT1, L, 0));
        vecs.push_back(mk(1, 0, 0, 32'h101, 32'hAABBCC55, 32'h0000DEAD, 0, LAT2, 2 * L, L));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,        32'hDEAD55EF, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 2, 0, 32'h101, 32'h0,        32'h00DEAD55, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 0, 1, 32'h101, 32'h0,        32'h00000055, 0, LAT1, L, 0));
        vecs.push_back(mk(1, 1, 1, 32'h201, 32'hA5A51234, 32'h00000055, 0, LAT2, 2 * L, L));
        vecs.push_back(mk(0, 2, 0, 32'h200, 32'h0,        32'h00123400, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 3, 0, 32'h100, 32'h0,        32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3, 0, 32'h100, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2, 0, 32'h100, 32'h0,        32'hDEAD55EF, 0, LAT1, L, 0));
`ifdef RANGE_CHECK_EN
        vecs.push_back(mk(0, 2, 0, 32'hFFE, 32'h0,        32'h00000000, 1, 1, 0, 0));
`else
        vecs.push_back(mk(0, 2, 0, 32'hFFE, 32'h0,        32'h00000000, 0, LAT1, L, 0));
`endif
        vecs.push_back(mk(1, 2, 0, 32'hFFC, 32'h80007F01, 32'h00000000, 0, LAT1, L, L));
        vecs.push_back(mk(0, 1, 1, 32'hFFC, 32'h0,        32'h00007F01, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 0, 1, 32'hFFD, 32'h0,        32'h0000007F, 0, LAT1, L, 0));
        vecs.push_back(mk(0, 2, 0, 32'hFFD, 32'h0,        32'h0080007F, 0, LAT1, L, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i]);
            if (vecs[i].we && !vecs[i].exp_err) ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
        end

        // Reset during the read-phase ACCESS of a half store
        r = 0;
        while (bus.req_ready !== 1'b1 && r < 20) begin
            @(negedge clk);
            r++;
        end
        bus.req_we = 1'b1; bus.req_size = 2'd1; bus.req_signed = 1'b0;
        bus.req_addr = 32'h300; bus.req_wdata = 32'h0000BEEF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_setup_addr", bus.mem_addr, IDLE);
        @(negedge clk);
        chk("abort_access_addr", bus.mem_addr, 32'h300);
        chk("abort_access_rw", 32'(bus.mem_rw), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem_addr", bus.mem_addr, IDLE);
        chk("abort_mem_rw", 32'(bus.mem_rw), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        chk("abort_no_response", 32'(seen), 32'd0);
        chk("abort_ready_back", 32'(bus.req_ready), 32'd1);
        $display("txn %0d abort half store at 00000300 by reset during access", txn_no);
        txn_no++;
        last_rdata = 32'h0;
        model_txn("after_abort", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, last_rdata);

        // Random traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] size;
            r = int'($urandom_range(0, 9));
            size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            model_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), size,
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'hFFD)),
                      $urandom, last_rdata);
        end

        // Final memory image must match the model byte for byte
        diffs = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (dev_mem[i] !== ref_mem[i]) diffs++;
        end
        chk("mem_image_diffs", 32'(diffs), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Processor-side initiator for the byte-addressed data memory's read/write port. Memory side: address, write data, rw, read data.
- Takes load/store requests from the pipeline over a valid/ready handshake and sequences the memory port.
- Memory reads and writes always cover 4 little-endian bytes. Byte and half stores are therefore done as read-modify-write. Loads are size-extracted and extended.
- The memory acts on address changes, so the address is parked at IDLE_ADDR between accesses.

Parameters:
- MEM_LAT, 1: cycles mem_addr is held per access; read data is captured on the last of them (≥1).
- IDLE_ADDR, 32'hFFFF_FFFF: parked address, outside the memory.
- MEM_TOP, 32'h0000_1000: highest valid byte address (used only with RANGE_CHECK_EN).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller idle, can accept
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_signed  in  1  sign-extend load (ignored for word/store)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used for byte/half
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result, held until next response
- rsp_err  out  1  error flag, valid with rsp_valid
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rw  out  1  0 read, 1 write
- mem_rdata  in  32  memory read data

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_addr=IDLE_ADDR, mem_wdata=0, mem_rw=0, state=IDLE. req_ready rises the first cycle after rst_n is released.
- Accept on a rising edge with req_valid&&req_ready. All req_* fields are latched there, and req_ready drops the same edge.
- States: IDLE, SETUP, ACCESS, PARK.
  - IDLE: req_ready=1, mem_addr=IDLE_ADDR, mem_rw=0.
  - SETUP (1 cycle): mem_addr stays at IDLE_ADDR. mem_rw and mem_wdata are driven for the coming access.
  - ACCESS (MEM_LAT cycles): mem_addr=latched addr; mem_rw and mem_wdata are stable. On the last cycle, mem_rdata is captured for a read phase.
  - PARK (1 cycle): mem_addr=IDLE_ADDR. A sub-word store's read phase goes back to SETUP for the write phase; otherwise rsp_valid=1 this cycle and the next state is IDLE.
- mem_rw may change only while mem_addr==IDLE_ADDR, and at least one cycle before mem_addr leaves it.
- Load and word-store paths:
  - Load: one read phase. rsp_valid is high MEM_LAT+2 edges after the accepting edge.
  - Word store: one write phase, mem_wdata=req_wdata. Same latency as a load.
- Byte/half store:
  - Read phase at addr, then write phase at addr.
  - Merged data: byte = {rd[31:8],wdata[7:0]}; half = {rd[31:16],wdata[15:0]}.
  - Latency 2*(MEM_LAT+2). rsp_rdata is unchanged by stores.
- Load extraction from the captured word rd:
  - byte: rd[7:0]; half: rd[15:0]; word: rd.
  - Extension: sign-extended if req_signed, zero-extended otherwise.
- Unaligned addresses are legal and need no special handling: the memory spans 4 consecutive bytes from any byte address.
- req_size=11: no memory access, mem_* unchanged. Go to PARK next edge with rsp_valid=1, rsp_err=1, rsp_rdata=0.
- No response backpressure: rsp_valid is a single-cycle pulse.
- The next request can be accepted on the edge after PARK (IDLE cycle).
- Reset mid-operation: the next edge with rst_n=0 aborts. All outputs take reset values and no rsp_valid is issued. A write already in ACCESS may already be committed in memory, and that is acceptable.

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined: any request with req_addr+3 > MEM_TOP (33-bit compare, so address wrap counts as out of range) gets the error path. That means no memory access, rsp_err=1, rsp_rdata=0, and rsp_valid one edge after accept.
- Undefined: no range check; the access is issued.

Test Plan:
1. Hold rst_n=0 for 3 cycles -> req_ready=0, mem_addr=32'hFFFF_FFFF, mem_rw=0, rsp_valid=0. req_ready=1 one cycle after release.
2. Word store 0xDEADBEEF at 0x100, then word load at 0x100, MEM_LAT=1 -> memory bytes 0x100..0x103 = EF,BE,AD,DE. Load rsp_rdata=0xDEADBEEF, rsp_valid 3 edges after accept, rsp_err=0.
3. After step 2: signed byte load at 0x103 -> 0xFFFFFFDE. Unsigned byte load at 0x103 -> 0x000000DE. Signed half load at 0x100 -> 0xFFFFBEEF.
4. Byte store 0x55 at 0x101 -> read then write phase, rsp_valid 6 edges after accept, mem_rw toggling only while mem_addr=IDLE_ADDR. A following word load at 0x100 returns 0xDEAD55EF.
5. req_size=11 -> rsp_err=1, rsp_rdata=0, mem_addr never leaves IDLE_ADDR. With RANGE_CHECK_EN, word load at 0xFFE gives the same error response; without it, the access is issued.
6. rst_n=0 for one cycle during ACCESS of a half store -> state IDLE, mem_addr=IDLE_ADDR, mem_rw=0, no rsp_valid. A new word load is accepted and completes normally afterwards.
